// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   funct3 encodings, mem_size encodings, fault cause codes and the FSM state type.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_LOAD_MIS  = 2'b01;
    localparam logic [1:0] CAUSE_STORE_MIS = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP, S_FAULT} state_t;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: execute-side request, data-RAM port, writeback and fault signals of the LSU.
//   slave  : the LSU itself (takes req_*/mem_dout, drives everything else)
//   master : the environment (execute stage, RAM, writeback)
interface lsu_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_store;
    logic [2:0]           req_funct3;
    logic [WORD_SIZE-1:0] req_base;
    logic [WORD_SIZE-1:0] req_offset;
    logic [WORD_SIZE-1:0] req_wdata;
    logic [4:0]           req_rd;
    logic                 mem_en_write;
    logic                 mem_en_read;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_din;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
    logic [WORD_SIZE-1:0] mem_dout;
    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 st_done;
    logic                 fault;
    logic [1:0]           fault_cause;
    logic [WORD_SIZE-1:0] fault_addr;
    modport slave (
        input  req_valid, req_store, req_funct3, req_base, req_offset, req_wdata, req_rd, mem_dout,
        output req_ready, mem_en_write, mem_en_read, mem_addr, mem_din, mem_size, mem_unsigned,
        output wb_valid, wb_rd, wb_data, st_done, fault, fault_cause, fault_addr
    );
    modport master (
        output req_valid, req_store, req_funct3, req_base, req_offset, req_wdata, req_rd, mem_dout,
        input  req_ready, mem_en_write, mem_en_read, mem_addr, mem_din, mem_size, mem_unsigned,
        input  wb_valid, wb_rd, wb_data, st_done, fault, fault_cause, fault_addr
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational funct3 decode, store lane replication and alignment handling.
//   i_store/i_funct3/i_addr_lo/i_wdata : request fields (low two effective-address bits)
//   o_size/o_unsigned                  : RAM access size and zero-extend flag
//   o_addr_lo                          : low address bits after forced alignment
//   o_din                              : lane-replicated store data
//   o_fault/o_cause                    : request must trap, and why
// LSU_MISALIGN_TRAP_EN defined: misaligned half/word accesses fault; otherwise they are forced aligned.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [1:0]  o_size,
    output logic        o_unsigned,
    output logic [1:0]  o_addr_lo,
    output logic [31:0] o_din,
    output logic        o_fault,
    output logic [1:0]  o_cause
);
    logic w_legal;
    logic [1:0] w_size;
`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
`endif
    always_comb begin
        w_legal = i_store ? (i_funct3 == F3_B || i_funct3 == F3_H || i_funct3 == F3_W)
                          : (i_funct3 == F3_B || i_funct3 == F3_H || i_funct3 == F3_W ||
                             i_funct3 == F3_BU || i_funct3 == F3_HU);
        w_size = i_funct3[1:0] == 2'b00 ? SIZE_B : i_funct3[1:0] == 2'b01 ? SIZE_H : SIZE_W;
        o_size = w_size;
        o_unsigned = i_funct3[2];
        o_din = w_size == SIZE_B ? {4{i_wdata[7:0]}} : w_size == SIZE_H ? {2{i_wdata[15:0]}} : i_wdata;
        o_addr_lo = w_size == SIZE_B ? i_addr_lo : w_size == SIZE_H ? {i_addr_lo[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        w_mis = w_size == SIZE_H ? i_addr_lo[0] : w_size == SIZE_W ? |i_addr_lo : 1'b0;
        o_fault = !w_legal || w_mis;
        o_cause = !w_legal ? CAUSE_ILLEGAL : !w_mis ? CAUSE_NONE : i_store ? CAUSE_STORE_MIS : CAUSE_LOAD_MIS;
`else
        o_fault = !w_legal;
        o_cause = w_legal ? CAUSE_NONE : CAUSE_ILLEGAL;
`endif
    end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, initiator side of the single-port data RAM.
//   clk, rst : clock and synchronous active-high reset
//   bus      : lsu_if.slave (request from execute, RAM port, writeback pulse, fault report)
// LSU_MISALIGN_TRAP_EN selects trapping versus forced alignment of misaligned accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    state_t r_state;
    state_t w_next;
    logic [31:0] w_ea;
    logic [1:0] w_size;
    logic w_unsigned;
    logic [1:0] w_addr_lo;
    logic [31:0] w_din;
    logic w_fault;
    logic [1:0] w_cause;
    logic w_accept;
    logic r_store;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_din;
    logic [1:0] r_size;
    logic r_unsigned;
    logic [4:0] r_rd;
    logic [WORD_SIZE-1:0] r_wb_data;
    logic [1:0] r_cause;
    logic [31:0] r_fault_addr;

    assign w_ea = bus.req_base + bus.req_offset;
    assign w_accept = r_state == S_IDLE && bus.req_valid;

    lsu_align u_align (
        .i_store    (bus.req_store),
        .i_funct3   (bus.req_funct3),
        .i_addr_lo  (w_ea[1:0]),
        .i_wdata    (bus.req_wdata),
        .o_size     (w_size),
        .o_unsigned (w_unsigned),
        .o_addr_lo  (w_addr_lo),
        .o_din      (w_din),
        .o_fault    (w_fault),
        .o_cause    (w_cause)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = !bus.req_valid ? S_IDLE : w_fault ? S_FAULT : S_ISSUE;
            S_ISSUE:   w_next = r_store ? S_IDLE : S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            default:   w_next = S_IDLE;
        endcase
        bus.req_ready = r_state == S_IDLE;
        bus.mem_en_read = r_state == S_ISSUE && !r_store;
        bus.mem_en_write = r_state == S_ISSUE && r_store;
        bus.st_done = r_state == S_ISSUE && r_store;
        bus.wb_valid = r_state == S_RESP;
        bus.fault = r_state == S_FAULT;
    end

    // The RAM extends its output from mem_size/mem_unsigned/mem_addr, so these only
    // change on acceptance and stay put through CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store <= 1'b0;
            r_addr <= '0;
            r_din <= '0;
            r_size <= SIZE_W;
            r_unsigned <= 1'b0;
            r_rd <= '0;
            r_wb_data <= '0;
            r_cause <= CAUSE_NONE;
            r_fault_addr <= '0;
        end else begin
            if (w_accept && w_fault) begin
                r_cause <= w_cause;
                r_fault_addr <= w_ea;
            end
            if (w_accept && !w_fault) begin
                r_store <= bus.req_store;
                r_addr <= {w_ea[ADDR_SIZE-1:2], w_addr_lo};
                r_din <= w_din;
                r_size <= w_size;
                r_unsigned <= w_unsigned;
                r_rd <= bus.req_rd;
            end
            if (r_state == S_CAPTURE) r_wb_data <= bus.mem_dout;
        end
    end

    assign bus.mem_addr = r_addr;
    assign bus.mem_din = r_din;
    assign bus.mem_size = r_size;
    assign bus.mem_unsigned = r_unsigned;
    assign bus.wb_rd = r_rd;
    assign bus.wb_data = r_wb_data;
    assign bus.fault_cause = r_cause;
    assign bus.fault_addr = r_fault_addr;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    lsu_if #(.ADDR_SIZE(10), .WORD_SIZE(32)) bus ();

    lsu #(.ADDR_SIZE(10), .WORD_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_funct3 = f3;
        bus.req_base = base;
        bus.req_offset = off;
        bus.req_wdata = wd;
        bus.req_rd = rd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        checks++; if ({bus.mem_en_read, bus.mem_en_write} !== 2'b00) begin errors++; $display("FAIL rst_en: got %b want 00", {bus.mem_en_read, bus.mem_en_write}); end
        checks++; if ({bus.wb_valid, bus.st_done, bus.fault} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {bus.wb_valid, bus.st_done, bus.fault}); end
        checks++; if (bus.mem_addr !== 10'h0 || bus.mem_din !== 32'h0) begin errors++; $display("FAIL rst_mem: got addr %h din %h want 0 0", bus.mem_addr, bus.mem_din); end
        checks++; if (bus.wb_data !== 32'h0 || bus.fault_addr !== 32'h0) begin errors++; $display("FAIL rst_data: got wb %h fa %h want 0 0", bus.wb_data, bus.fault_addr); end
        checks++; if (bus.mem_size !== 2'b10 || bus.mem_unsigned !== 1'b0) begin errors++; $display("FAIL rst_size: got %b/%b want 10/0", bus.mem_size, bus.mem_unsigned); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw;
        drive(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if ({bus.mem_en_read, bus.mem_en_write} !== 2'b10) begin errors++; $display("FAIL lw_en: got %b want 10", {bus.mem_en_read, bus.mem_en_write}); end
        checks++; if (bus.mem_addr !== 10'h104 || bus.mem_size !== 2'b10) begin errors++; $display("FAIL lw_addr: got %h/%b want 104/10", bus.mem_addr, bus.mem_size); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL lw_ready_issue: got %b want 0", bus.req_ready); end
        bus.mem_dout = 32'h12345678;
        @(negedge clk);
        checks++; if ({bus.mem_en_read, bus.wb_valid} !== 2'b00 || bus.mem_addr !== 10'h104) begin errors++; $display("FAIL lw_capture: got en %b wbv %b addr %h want 0 0 104", bus.mem_en_read, bus.wb_valid, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h12345678 || bus.wb_rd !== 5'd5) begin errors++; $display("FAIL lw_wb: got %b %h rd %0d want 1 12345678 rd 5", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lw_idle: got ready %b wbv %b want 1 0", bus.req_ready, bus.wb_valid); end
    endtask

    task automatic test_lb_lbu;
        drive(1'b0, 3'b000, 32'h0, 32'h3, 32'h0, 5'd7);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_addr !== 10'h003 || bus.mem_size !== 2'b00 || bus.mem_unsigned !== 1'b0) begin errors++; $display("FAIL lb_issue: got %h/%b/%b want 003/00/0", bus.mem_addr, bus.mem_size, bus.mem_unsigned); end
        bus.mem_dout = 32'hFFFFFF80;
        repeat (2) @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_wb: got %b %h want 1 ffffff80", bus.wb_valid, bus.wb_data); end
        @(negedge clk);
        drive(1'b0, 3'b100, 32'h3, 32'h0, 32'h0, 5'd8);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_unsigned !== 1'b1 || bus.mem_size !== 2'b00) begin errors++; $display("FAIL lbu_issue: got uns %b size %b want 1 00", bus.mem_unsigned, bus.mem_size); end
        bus.mem_dout = 32'h00000080;
        @(negedge clk);
        checks++; if (bus.mem_unsigned !== 1'b1 || bus.mem_addr !== 10'h003) begin errors++; $display("FAIL lbu_hold: got uns %b addr %h want 1 003", bus.mem_unsigned, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.wb_data !== 32'h00000080 || bus.wb_rd !== 5'd8) begin errors++; $display("FAIL lbu_wb: got %h rd %0d want 00000080 rd 8", bus.wb_data, bus.wb_rd); end
        @(negedge clk);
    endtask

    task automatic test_stores;
        drive(1'b1, 3'b000, 32'h2, 32'h0, 32'h000000AB, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if ({bus.mem_en_write, bus.mem_en_read, bus.st_done} !== 3'b101) begin errors++; $display("FAIL sb_pulse: got %b want 101", {bus.mem_en_write, bus.mem_en_read, bus.st_done}); end
        checks++; if (bus.mem_din !== 32'hABABABAB || bus.mem_size !== 2'b00 || bus.mem_addr !== 10'h002) begin errors++; $display("FAIL sb_data: got %h/%b/%h want abababab/00/002", bus.mem_din, bus.mem_size, bus.mem_addr); end
        @(negedge clk);
        checks++; if ({bus.mem_en_write, bus.st_done, bus.req_ready} !== 3'b001) begin errors++; $display("FAIL sb_idle: got %b want 001", {bus.mem_en_write, bus.st_done, bus.req_ready}); end
        drive(1'b1, 3'b001, 32'h14, 32'hFFFFFFFC, 32'h1234ABCD, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_din !== 32'hABCDABCD || bus.mem_size !== 2'b01 || bus.mem_addr !== 10'h010) begin errors++; $display("FAIL sh_data: got %h/%b/%h want abcdabcd/01/010", bus.mem_din, bus.mem_size, bus.mem_addr); end
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h418, 32'hFFFFFFF8, 32'hCAFEF00D, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_din !== 32'hCAFEF00D || bus.mem_addr !== 10'h010 || bus.mem_en_write !== 1'b1) begin errors++; $display("FAIL sw_alias: got %h/%h/%b want cafef00d/010/1", bus.mem_din, bus.mem_addr, bus.mem_en_write); end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        drive(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 5'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b01 || bus.fault_addr !== 32'h1) begin errors++; $display("FAIL lh_mis_fault: got %b/%b/%h want 1/01/00000001", bus.fault, bus.fault_cause, bus.fault_addr); end
        checks++; if ({bus.mem_en_read, bus.mem_en_write} !== 2'b00) begin errors++; $display("FAIL lh_mis_en: got %b want 00", {bus.mem_en_read, bus.mem_en_write}); end
        @(negedge clk);
        checks++; if (bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL lh_mis_idle: got %b/%b want 0/1", bus.fault, bus.req_ready); end
        drive(1'b1, 3'b010, 32'h6, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b10 || bus.fault_addr !== 32'h6 || bus.mem_en_write !== 1'b0) begin errors++; $display("FAIL sw_mis_fault: got %b/%b/%h/%b want 1/10/00000006/0", bus.fault, bus.fault_cause, bus.fault_addr, bus.mem_en_write); end
        @(negedge clk);
`else
        checks++; if (bus.mem_en_read !== 1'b1 || bus.mem_addr !== 10'h000 || bus.fault !== 1'b0) begin errors++; $display("FAIL lh_align: got en %b addr %h fault %b want 1 000 0", bus.mem_en_read, bus.mem_addr, bus.fault); end
        bus.mem_dout = 32'hFFFF8001;
        repeat (2) @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFFFF8001 || bus.wb_rd !== 5'd3) begin errors++; $display("FAIL lh_align_wb: got %b %h rd %0d want 1 ffff8001 rd 3", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h6, 32'h0, 32'h5A5A5A5A, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_en_write !== 1'b1 || bus.mem_addr !== 10'h004 || bus.fault !== 1'b0) begin errors++; $display("FAIL sw_align: got en %b addr %h fault %b want 1 004 0", bus.mem_en_write, bus.mem_addr, bus.fault); end
        @(negedge clk);
`endif
    endtask

    task automatic test_illegal;
        drive(1'b1, 3'b011, 32'h20, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b11 || bus.fault_addr !== 32'h20) begin errors++; $display("FAIL st_illegal: got %b/%b/%h want 1/11/00000020", bus.fault, bus.fault_cause, bus.fault_addr); end
        checks++; if ({bus.mem_en_read, bus.mem_en_write, bus.st_done} !== 3'b000) begin errors++; $display("FAIL st_illegal_en: got %b want 000", {bus.mem_en_read, bus.mem_en_write, bus.st_done}); end
        @(negedge clk);
        drive(1'b0, 3'b110, 32'h44, 32'h0, 32'h0, 5'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b11 || bus.fault_addr !== 32'h44 || bus.mem_en_read !== 1'b0) begin errors++; $display("FAIL ld_illegal: got %b/%b/%h/%b want 1/11/00000044/0", bus.fault, bus.fault_cause, bus.fault_addr, bus.mem_en_read); end
        @(negedge clk);
        checks++; if (bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL illegal_idle: got %b/%b want 0/1", bus.fault, bus.req_ready); end
    endtask

    task automatic test_reset_capture;
        drive(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd9);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_dout = 32'hDEADBEEF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.mem_en_read !== 1'b0) begin errors++; $display("FAIL rstcap_state: got ready %b wbv %b en %b want 1 0 0", bus.req_ready, bus.wb_valid, bus.mem_en_read); end
        checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rstcap_data: got %h want 00000000", bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstcap_after: got wbv %b ready %b want 0 1", bus.wb_valid, bus.req_ready); end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd1);
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 5'd2);
        checks++; if (bus.req_ready !== 1'b0 || bus.mem_addr !== 10'h040) begin errors++; $display("FAIL b2b_issue1: got ready %b addr %h want 0 040", bus.req_ready, bus.mem_addr); end
        bus.mem_dout = 32'h11111111;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0 || bus.mem_addr !== 10'h040 || bus.mem_en_read !== 1'b0) begin errors++; $display("FAIL b2b_capture1: got ready %b addr %h en %b want 0 040 0", bus.req_ready, bus.mem_addr, bus.mem_en_read); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h11111111 || bus.wb_rd !== 5'd1) begin errors++; $display("FAIL b2b_wb1: got ready %b wbv %b %h rd %0d want 0 1 11111111 rd 1", bus.req_ready, bus.wb_valid, bus.wb_data, bus.wb_rd); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_en_read !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready %b en %b wbv %b want 1 0 0", bus.req_ready, bus.mem_en_read, bus.wb_valid); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_en_read !== 1'b1 || bus.mem_addr !== 10'h080) begin errors++; $display("FAIL b2b_issue2: got en %b addr %h want 1 080", bus.mem_en_read, bus.mem_addr); end
        bus.mem_dout = 32'h22222222;
        repeat (2) @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h22222222 || bus.wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_wb2: got wbv %b %h rd %0d want 1 22222222 rd 2", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_base = 32'h0;
        bus.req_offset = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd = 5'd0;
        bus.mem_dout = 32'h0;
        test_reset;
        test_lw;
        test_lb_lbu;
        test_stores;
        test_misaligned;
        test_illegal;
        test_reset_capture;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RISC-V core: the initiator side of the data-memory port. Accepts one load or store per transaction from the execute stage, computes the effective address, checks alignment, drives the single-port data RAM (one-cycle registered read, byte-lane write enables derived in the RAM from size and offset) and returns sign/zero-extended load data to writeback. It sits between execute and `d_mem`, and stalls the pipeline through `req_ready` while a transaction is in flight.

## Interface
- `ADDR_SIZE`, 10: byte-address width of the data RAM.
- `WORD_SIZE`, 32: data width; only 32 is supported.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_base` in 32: rs1 value.
- `req_offset` in 32: sign-extended immediate.
- `req_wdata` in 32: rs2 value.
- `req_rd` in 5: load destination register.
- `mem_en_write`, `mem_en_read` out 1: RAM enables.
- `mem_addr` out ADDR_SIZE: RAM byte address.
- `mem_din` out 32: lane-replicated store data.
- `mem_size` out 2: 00 byte, 01 half, 10 word.
- `mem_unsigned` out 1: 1 = zero-extend.
- `mem_dout` in 32: extended read data, valid in the cycle after the read edge.
- `wb_valid` out 1: one-cycle load-result pulse.
- `wb_rd` out 5, `wb_data` out 32: load result.
- `st_done` out 1: one-cycle store-complete pulse.
- `fault` out 1, `fault_cause` out 2, `fault_addr` out 32: exception report.

## Operation
- The effective address is `req_base + req_offset`, mod 2^32. `mem_addr` carries address[ADDR_SIZE-1:0]; upper bits are ignored (aliasing).
- Load decode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store decode: 000 SB, 001 SH, 010 SW. Any other funct3 raises fault cause 11.
- Store data: byte gives `{4{wdata[7:0]}}`, half gives `{2{wdata[15:0]}}`, word gives `wdata`.
- Misaligned accesses are a half access with addr[0]=1, or a word access with addr[1:0]≠0. Handling is covered under Configuration.
- FSM states are IDLE, ISSUE, CAPTURE, RESP and FAULT.
- IDLE, on `req_valid`: a legal request goes to ISSUE and the request is registered. A faulting request goes to FAULT.
- ISSUE: exactly one of `mem_en_read`/`mem_en_write` is high for one cycle, and all `mem_*` outputs come from registers. A store goes to IDLE with `st_done` high in that cycle. A load goes to CAPTURE.
- CAPTURE: enables low. `mem_dout` is registered into `wb_data`. Next state is RESP.
- RESP: `wb_valid`=1 with `wb_rd`. Next state is IDLE.
- FAULT: `fault`=1 with the registered cause and address, and no RAM enable is asserted. Next state is IDLE.
- Fault causes: 01 load misaligned, 10 store misaligned, 11 illegal funct3.
- `rd`=0 loads run normally; the register file discards the write.

## Timing
- Reset state is IDLE. `req_ready`=1. All enables, `wb_valid`, `st_done` and `fault` are 0. `mem_addr`, `mem_din`, `wb_data` and `fault_addr` are 0. `mem_size`=10 and `mem_unsigned`=0.
- Load: accepted at edge E0. Enable is high in cycle E0–E1. Data is captured at E2. `wb_valid` is high in cycle E2–E3. That gives 4 cycles from acceptance to IDLE.
- Store: accepted at E0, write occurs at E1, `st_done` is high in E0–E1. That gives 2 cycles from acceptance to IDLE.
- Fault: `fault` is high in the cycle after acceptance.
- `req_ready`=0 in every non-IDLE state. Requests are ignored while not ready, so upstream must hold them.
- `rst` asserted in any state: IDLE at the next edge. Enables drop at that edge, and no `wb_valid`, `st_done` or `fault` pulse follows.
- `mem_size`, `mem_unsigned` and `mem_addr` are held stable through CAPTURE, because the RAM extends its output combinationally from them.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses go to FAULT with cause 01 or 10.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned addresses are forced aligned (half clears bit 0, word clears bits 1:0) and the access proceeds. `fault_cause` 01/10 is never produced.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants;
  - the `mem_size` encodings;
  - fault cause codes;
  - the FSM state typedef.
- Sub-module `lsu_align` is combinational. It decodes funct3 into size, unsigned and legality, performs lane replication, and does the misalignment check and forced alignment.
- The FSM and registers live in `lsu`.

## Test plan
- **LW:** LW with base 0x100 and offset 0x4 → `mem_addr`=0x104, `mem_size`=10, one read pulse. With `mem_dout`=0x12345678, `wb_valid` appears 2 cycles after the read pulse with `wb_data`=0x12345678.
- **LB / LBU:** LB at address 0x003 with `mem_dout`=0xFFFFFF80 gives `wb_data`=0xFFFFFF80. LBU with `mem_dout`=0x00000080 gives 0x00000080 and `mem_unsigned`=1.
- **SB:** SB at address 0x002 with `wdata`=0x000000AB → `mem_din`=0xABABABAB, `mem_size`=00, `mem_addr`=0x002, a single write pulse and `st_done` in the same cycle.
- **Misaligned LH:** LH at address 0x001 with the macro defined → `fault`=1, cause 01, `fault_addr`=0x1, and no enable. With the macro undefined → `mem_addr`=0x000 and a normal load.
- **Illegal funct3 and reset:** funct3=011 store → fault cause 11. Reset asserted in CAPTURE → `wb_valid` is never asserted and `req_ready`=1 on the next cycle.
- **Back-to-back loads:** two loads with `req_valid` held → `req_ready` low for 3 cycles, the second request is accepted only in IDLE, and both writebacks appear in order.
